// File: rtl/txn_fsm_if.sv
// txn_fsm_if: start/ack handshake bundle between a transaction initiator and txn_fsm.
// The abort signal exists only when TXN_FSM_ABORT_EN is defined.
interface txn_fsm_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic              req;
  logic [DATA_W-1:0] req_data;
  logic              ack;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [3:0]        retries;
`ifdef TXN_FSM_ABORT_EN
  logic              abort;
`endif
  modport master (
`ifdef TXN_FSM_ABORT_EN
    output abort,
`endif
    output start, din, ack, rsp_data,
    input  req, req_data, rdata, busy, done, err, retries
  );
  modport slave (
`ifdef TXN_FSM_ABORT_EN
    input  abort,
`endif
    input  start, din, ack, rsp_data,
    output req, req_data, rdata, busy, done, err, retries
  );
endinterface

// File: rtl/txn_fsm.sv
// txn_fsm: request/ack transaction engine with per-attempt timeout, retries and one-cycle backoff.
// Define TXN_FSM_ABORT_EN to add an abort input that forces ERR from REQ or BACKOFF.
module txn_fsm #(
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic     clk,
  input  logic     rstn,
  txn_fsm_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_BACKOFF, S_DONE, S_ERR} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        retries_q, retries_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              abort;
`ifdef TXN_FSM_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retries_d  = retries_q;
    req_data_d = req_data_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        req_data_d = bus.din;
        retries_d  = '0;
        cnt_d      = '0;
        state_d    = S_REQ;
      end
      S_REQ: begin
        // abort beats ack, and ack beats a timeout landing in the same cycle
        if (abort) state_d = S_ERR;
        else if (bus.ack) begin
          rdata_d = bus.rsp_data;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1))
          state_d = (retries_q < 4'(MAX_RETRY)) ? S_BACKOFF : S_ERR;
        else cnt_d = cnt_q + CW'(1);
      end
      S_BACKOFF: begin
        retries_d = retries_q + 4'd1;
        cnt_d     = '0;
        state_d   = abort ? S_ERR : S_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retries_q  <= '0;
      req_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      req_data_q <= req_data_d;
      rdata_q    <= rdata_d;
    end
  end
  assign bus.req      = state_q == S_REQ;
  assign bus.busy     = state_q != S_IDLE;
  assign bus.done     = state_q == S_DONE;
  assign bus.err      = state_q == S_ERR;
  assign bus.retries  = retries_q;
  assign bus.req_data = req_data_q;
  assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_txn_fsm.sv
// tb_txn_fsm: randomized bench for txn_fsm; expectations come from a timeline model of
// req bursts (TIMEOUT cycles each, 1-cycle gaps) rather than from the FSM states.
module tb_txn_fsm;
  localparam int DW = 8, T = 4, MR = 2, P = T + 1;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0, errors = 0;
  logic [DW-1:0] rdata_exp = '0;
  logic [3:0] retries_exp = '0;
  txn_fsm_if #(.DATA_W(DW)) bus();
  txn_fsm #(.DATA_W(DW), .TIMEOUT(T), .MAX_RETRY(MR)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(string tag);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".req"}, 64'(bus.req), 64'd0);
    chk({tag, ".done"}, 64'(bus.done), 64'd0);
    chk({tag, ".err"}, 64'(bus.err), 64'd0);
    chk({tag, ".rdata"}, 64'(bus.rdata), 64'(rdata_exp));
    chk({tag, ".retries"}, 64'(bus.retries), 64'(retries_exp));
  endtask
  task automatic set_abort(bit v);
`ifdef TXN_FSM_ABORT_EN
    bus.abort = v;
`else
    if (v) $display("note: abort requested without abort support");
`endif
  endtask
  // Req index n (0-based over all req-high cycles) maps to cycle 1 + (n/T)*P + n%T after start.
  function automatic int idx_to_cycle(int n);
    return (n >= 0 && n < (MR + 1) * T) ? 1 + (n / T) * P + n % T : -1;
  endfunction
  task automatic run_txn(logic [DW-1:0] din, int ack_idx, logic [DW-1:0] rsp, int abort_idx, bit noise);
    int ack_c, abort_c, end_c;
    bit ok, in_req;
    ack_c   = idx_to_cycle(ack_idx);
    abort_c = idx_to_cycle(abort_idx);
    if (abort_c > 0 && (ack_c < 0 || abort_c <= ack_c)) begin
      end_c = abort_c + 1;
      ok = 1'b0;
    end else if (ack_c > 0) begin
      end_c = ack_c + 1;
      ok = 1'b1;
    end else begin
      end_c = (MR + 1) * P;
      ok = 1'b0;
    end
    bus.start    = 1'b1;
    bus.din      = din;
    bus.ack      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.rsp_data = DW'($urandom);
    set_abort(1'b0);
    for (int c = 1; c <= end_c + 1; c++) begin
      @(posedge clk);
      #1;
      in_req = c < end_c && (c - 1) % P < T;
      if (c <= end_c) begin
        if (ok && c == end_c) rdata_exp = rsp;
        retries_exp = 4'((c - 1) / P);
        chk("txn.req", 64'(bus.req), 64'(in_req));
        chk("txn.busy", 64'(bus.busy), 64'd1);
        chk("txn.done", 64'(bus.done), 64'(ok && c == end_c));
        chk("txn.err", 64'(bus.err), 64'(!ok && c == end_c));
        chk("txn.retries", 64'(bus.retries), 64'(retries_exp));
        chk("txn.req_data", 64'(bus.req_data), 64'(din));
        chk("txn.rdata", 64'(bus.rdata), 64'(rdata_exp));
      end else chk_idle("post");
      if (c == end_c + 1) begin
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        set_abort(1'b0);
      end else begin
        bus.start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.din      = DW'($urandom);
        bus.ack      = (c == ack_c) ? 1'b1 : (!in_req && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.rsp_data = (c == ack_c) ? rsp : DW'($urandom);
        set_abort(c == abort_c);
      end
    end
  endtask
  initial begin
    int ai, bi;
    bus.start = 1'b0;
    bus.din = '0;
    bus.ack = 1'b0;
    bus.rsp_data = '0;
    set_abort(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset.req_data", 64'(bus.req_data), 64'd0);
    rstn = 1'b1;
    run_txn(8'hA5, 2, 8'h3C, -1, 1'b0);
    run_txn(8'h5A, -1, 8'h00, -1, 1'b0);
    run_txn(8'hC3, T + 3, 8'h99, -1, 1'b0);
    run_txn(8'h11, 1, 8'h22, -1, 1'b1);
`ifdef TXN_FSM_ABORT_EN
    run_txn(8'hAA, 1, 8'h55, 1, 1'b0);
`endif
    bus.start = 1'b1;
    bus.din = 8'h77;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (T) @(posedge clk);
    #1;
    chk("bo.req", 64'(bus.req), 64'd0);
    chk("bo.busy", 64'(bus.busy), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    rdata_exp = '0;
    retries_exp = '0;
    chk_idle("async_rst");
    chk("async_rst.req_data", 64'(bus.req_data), 64'd0);
    @(posedge clk);
    #1;
    chk_idle("held_rst");
    rstn = 1'b1;
    run_txn(8'h3E, T + 1, 8'hE3, -1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      ai = int'($urandom_range(0, (MR + 1) * T + 3));
`ifdef TXN_FSM_ABORT_EN
      bi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (MR + 1) * T - 1)) : -1;
`else
      bi = -1;
`endif
      run_txn(DW'($urandom), ai, DW'($urandom), bi, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/txn_fsm.md
TXN_FSM -- requirements
Module: txn_fsm

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the request and response data in bits (range 1..64).
REQ-002 Parameter TIMEOUT, default 16, SHALL set the number of cycles req is held per attempt without ack (range 2..65535).
REQ-003 Parameter MAX_RETRY, default 3, SHALL set the number of retries after the first attempt (range 0..15).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 start  input  1  SHALL launch a transaction when sampled high in IDLE.
REQ-007 din  input  DATA_W  SHALL carry the request payload, sampled with start.
REQ-008 req  output  1  SHALL be the request strobe to the responder.
REQ-009 req_data  output  DATA_W  SHALL hold the captured payload while a transaction is active.
REQ-010 ack  input  1  SHALL be the responder acknowledge.
REQ-011 rsp_data  input  DATA_W  SHALL be the response payload, valid with ack.
REQ-012 rdata  output  DATA_W  SHALL be the last captured response.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 done  output  1  SHALL be the one-cycle success pulse.
REQ-015 err  output  1  SHALL be the one-cycle failure pulse.
REQ-016 retries  output  4  SHALL show the retry count of the current or last transaction.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, BACKOFF, DONE and ERR, all outputs Moore-decoded from registered state and registers.
REQ-018 IDLE with start=1 SHALL capture din into req_data, clear retries and the cycle counter, and go to REQ next cycle; start=0 stays in IDLE.
REQ-019 REQ SHALL drive req=1; each cycle without ack increments the cycle counter (width ceil(log2(TIMEOUT))).
REQ-020 REQ with ack=1 SHALL capture rsp_data into rdata and go to DONE.
REQ-021 REQ with ack=0 and counter==TIMEOUT-1 SHALL go to BACKOFF if retries<MAX_RETRY, else to ERR; req is therefore high exactly TIMEOUT cycles per failed attempt.
REQ-022 ack and timeout in the same cycle SHALL resolve as ack (DONE).
REQ-023 BACKOFF SHALL last one cycle with req=0, increment retries, clear the counter, and return to REQ.
REQ-024 DONE SHALL assert done for one cycle and go to IDLE; ERR SHALL assert err for one cycle and go to IDLE.
REQ-025 start while busy=1, and ack outside REQ, SHALL be ignored.
REQ-026 rdata SHALL hold its value until the next successful capture; it is not cleared by ERR.
REQ-027 MAX_RETRY=0 SHALL give a single attempt followed directly by ERR on timeout.

Reset
REQ-028 rstn low SHALL immediately force state IDLE, req=0, busy=0, done=0, err=0, req_data=0, rdata=0, retries=0, counter=0, including mid-transaction.
REQ-029 The first start after rstn deassertion SHALL be honoured on the first rising edge with rstn high.

Configuration
REQ-030 With macro TXN_FSM_ABORT_EN defined, a 1-bit input abort SHALL exist; abort=1 in REQ or BACKOFF moves to ERR next cycle (priority over ack and timeout), and abort is ignored in other states.
REQ-031 Without TXN_FSM_ABORT_EN, the abort port SHALL be absent and the behaviour identical to REQ-017..027.

Verification (DATA_W=8, TIMEOUT=4, MAX_RETRY=2)
REQ-032 start with din=0xA5 at cycle 0, ack with rsp_data=0x3C at cycle 3 -> req high cycles 1-3, done pulse at cycle 4, rdata=0x3C, retries=0, busy low from cycle 5.
REQ-033 start with ack never asserted -> three req bursts of 4 cycles separated by 1-cycle gaps, err pulse once, retries=2, rdata unchanged.
REQ-034 ack on the 4th req cycle of attempt 2 (timeout cycle) -> done pulse, no err, retries=1.
REQ-035 rstn pulsed low during BACKOFF -> all outputs are zero asynchronously, and a subsequent start runs a clean transaction with retries=0.
REQ-036 start held high across a full transaction, plus ack asserted while IDLE -> exactly one transaction per IDLE entry, and the stray ack has no effect.
REQ-037 TXN_FSM_ABORT_EN defined, abort at the 2nd req cycle with ack=1 in the same cycle -> err pulse next cycle, no done, rdata unchanged.
